dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: steps a phase increment through N points,
// settling, measuring and handing each point to the acquisition side.
module dds_sweep_ctrl #(
   parameter int PHASE_W = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [PHASE_W-1:0] phi_start,
   input  logic [PHASE_W-1:0] phi_step,
   input  logic [CNT_W-1:0]   n_points,
   input  logic [CNT_W-1:0]   settle_cycles,
   input  logic [CNT_W-1:0]   meas_cycles,
   input  logic               acq_ready,
   output logic [PHASE_W-1:0] phi_inc_o,
   output logic               dds_clken,
   output logic               meas_window,
   output logic               point_valid,
   output logic [CNT_W-1:0]   point_idx,
   output logic               busy,
   output logic               done,
   output logic               aborted
);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      MEASURE,
      WAIT_ACK,
      DONE
   } state_t;

   state_t state;

   logic [PHASE_W-1:0] step_q;
   logic [CNT_W-1:0]   n_q;
   logic [CNT_W-1:0]   settle_q;
   logic [CNT_W-1:0]   meas_q;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   settle_last;
   logic [CNT_W-1:0]   meas_last;
   logic [CNT_W-1:0]   idx_last;

   // Terminal counts; zero lengths behave as one cycle, so cnt never wraps.
   always_comb begin
      settle_last = '0;
      meas_last   = '0;
      if (settle_q > CNT_W'(1))
         settle_last = settle_q - CNT_W'(1);
      if (meas_q > CNT_W'(1))
         meas_last = meas_q - CNT_W'(1);
      idx_last = n_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         step_q      <= '0;
         n_q         <= '0;
         settle_q    <= '0;
         meas_q      <= '0;
         cnt         <= '0;
         phi_inc_o   <= '0;
         dds_clken   <= 1'b0;
         meas_window <= 1'b0;
         point_valid <= 1'b0;
         point_idx   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  step_q   <= phi_step;
                  n_q      <= n_points;
                  settle_q <= settle_cycles;
                  meas_q   <= meas_cycles;
                  if (n_points != '0) begin
                     state     <= SETTLE;
                     cnt       <= '0;
                     phi_inc_o <= phi_start;
                     point_idx <= '0;
                     dds_clken <= 1'b1;
                     busy      <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            SETTLE: begin
               if (abort) begin
                  state       <= IDLE;
                  aborted     <= 1'b1;
                  dds_clken   <= 1'b0;
                  meas_window <= 1'b0;
                  point_valid <= 1'b0;
                  busy        <= 1'b0;
               end else if (cnt == settle_last) begin
                  state       <= MEASURE;
                  cnt         <= '0;
                  meas_window <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            MEASURE: begin
               if (abort) begin
                  state       <= IDLE;
                  aborted     <= 1'b1;
                  dds_clken   <= 1'b0;
                  meas_window <= 1'b0;
                  point_valid <= 1'b0;
                  busy        <= 1'b0;
               end else if (cnt == meas_last) begin
                  state       <= WAIT_ACK;
                  cnt         <= '0;
                  meas_window <= 1'b0;
                  point_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_ACK: begin
               if (abort) begin
                  state       <= IDLE;
                  aborted     <= 1'b1;
                  dds_clken   <= 1'b0;
                  meas_window <= 1'b0;
                  point_valid <= 1'b0;
                  busy        <= 1'b0;
               end else if (acq_ready) begin
                  point_valid <= 1'b0;
                  if (point_idx == idx_last) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     dds_clken <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     state     <= SETTLE;
                     cnt       <= '0;
                     point_idx <= point_idx + CNT_W'(1);
                     phi_inc_o <= phi_inc_o + step_q;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: nominal, wrap, backpressure,
// zero-length, abort and asynchronous reset scenarios.
module tb_dds_sweep_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic [31:0] phi_start;
   logic [31:0] phi_step;
   logic [15:0] n_points;
   logic [15:0] settle_cycles;
   logic [15:0] meas_cycles;
   logic        acq_ready;
   logic [31:0] phi_inc_o;
   logic        dds_clken;
   logic        meas_window;
   logic        point_valid;
   logic [15:0] point_idx;
   logic        busy;
   logic        done;
   logic        aborted;

   int n_cmp = 0;
   int n_err = 0;

   int m_set, m_meas, m_pv, m_done, m_clk;
   logic [31:0] phis [4];

   dds_sweep_ctrl #(.PHASE_W(32), .CNT_W(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .phi_start     (phi_start),
      .phi_step      (phi_step),
      .n_points      (n_points),
      .settle_cycles (settle_cycles),
      .meas_cycles   (meas_cycles),
      .acq_ready     (acq_ready),
      .phi_inc_o     (phi_inc_o),
      .dds_clken     (dds_clken),
      .meas_window   (meas_window),
      .point_valid   (point_valid),
      .point_idx     (point_idx),
      .busy          (busy),
      .done          (done),
      .aborted       (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [31:0] ps, input logic [31:0] st,
                      input logic [15:0] n, input logic [15:0] s,
                      input logic [15:0] m);
      phi_start     = ps;
      phi_step      = st;
      n_points      = n;
      settle_cycles = s;
      meas_cycles   = m;
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Count per-state cycles from the current sample until done.
   task automatic mon(input int budget);
      int to;
      m_set  = 0;
      m_meas = 0;
      m_pv   = 0;
      m_done = 0;
      m_clk  = 0;
      to     = 1;
      for (int i = 0; i < budget; i++) begin
         if (dds_clken) m_clk++;
         if (dds_clken && !meas_window && !point_valid) m_set++;
         if (meas_window) m_meas++;
         if (point_valid) begin
            m_pv++;
            phis[point_idx[1:0]] = phi_inc_o;
         end
         if (done) begin
            m_done++;
            to = 0;
            break;
         end
         tick();
      end
      check("mon_timeout", to, 0);
   endtask

   initial begin
      int held;
      int to;
      int dn;
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      acq_ready = 1'b1;
      cfg(32'h0, 32'h0, 16'd0, 16'd0, 16'd0);
      for (int i = 0; i < 4; i++) phis[i] = '0;
      tick();
      tick();
      check("rst_phi", phi_inc_o, 0);
      check("rst_flags", {24'd0, dds_clken, meas_window, point_valid,
            busy, done, aborted, 2'b00}, 0);
      check("rst_idx", 32'(point_idx), 0);
      reset = 1'b0;
      tick();

      // Nominal sweep; config changed mid-sweep must not matter.
      cfg(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd4, 16'd8);
      kick();
      phi_step = 32'hDEAD_BEEF;
      n_points = 16'd9;
      check("nom_phi0", phi_inc_o, 32'h0100_0000);
      check("nom_idx0", 32'(point_idx), 0);
      check("nom_clken", 32'(dds_clken), 1);
      check("nom_busy", 32'(busy), 1);
      mon(200);
      check("nom_settle", m_set, 12);
      check("nom_meas", m_meas, 24);
      check("nom_pv", m_pv, 3);
      check("nom_p0", phis[0], 32'h0100_0000);
      check("nom_p1", phis[1], 32'h0110_0000);
      check("nom_p2", phis[2], 32'h0120_0000);
      check("nom_done_busy", 32'(busy), 0);
      check("nom_done_clk", 32'(dds_clken), 0);
      tick();
      check("nom_done_1cy", 32'(done), 0);
      check("nom_hold_phi", phi_inc_o, 32'h0120_0000);
      check("nom_hold_idx", 32'(point_idx), 2);
      tick();

      // Phase wrap.
      cfg(32'hFFFF_FFF0, 32'h0000_0020, 16'd2, 16'd1, 16'd1);
      kick();
      mon(100);
      check("wrap_p0", phis[0], 32'hFFFF_FFF0);
      check("wrap_p1", phis[1], 32'h0000_0010);
      check("wrap_done", m_done, 1);
      tick();

      // Backpressure in WAIT_ACK.
      cfg(32'h0000_1000, 32'h0000_0100, 16'd2, 16'd2, 16'd2);
      acq_ready = 1'b0;
      kick();
      to = 1;
      for (int i = 0; i < 50; i++) begin
         if (point_valid) begin
            to = 0;
            break;
         end
         tick();
      end
      check("bp_reach", to, 0);
      held = 0;
      for (int i = 0; i < 10; i++) begin
         if (point_valid && point_idx == 0 && phi_inc_o == 32'h1000)
            held++;
         tick();
      end
      check("bp_held", held, 10);
      check("bp_pv11", 32'(point_valid), 1);
      acq_ready = 1'b1;
      tick();
      check("bp_pv_clr", 32'(point_valid), 0);
      check("bp_idx", 32'(point_idx), 1);
      check("bp_phi", phi_inc_o, 32'h0000_1100);
      check("bp_settle", 32'(dds_clken && !meas_window), 1);
      mon(100);
      check("bp_done", m_done, 1);
      tick();

      // n_points == 0.
      cfg(32'h1234_5678, 32'h1, 16'd0, 16'd3, 16'd3);
      kick();
      check("z_done", 32'(done), 1);
      check("z_clk", 32'(dds_clken || meas_window), 0);
      check("z_busy", 32'(busy), 0);
      tick();
      check("z_done_1cy", 32'(done), 0);
      check("z_clk2", 32'(dds_clken), 0);

      // settle=0, meas=0 act as one cycle each.
      cfg(32'h0000_0040, 32'h1, 16'd1, 16'd0, 16'd0);
      kick();
      mon(50);
      check("z0_settle", m_set, 1);
      check("z0_meas", m_meas, 1);
      check("z0_pv", m_pv, 1);
      tick();

      // Abort in MEASURE of point 1 with simultaneous acq_ready.
      cfg(32'h0000_0800, 32'h0000_0008, 16'd3, 16'd2, 16'd4);
      acq_ready = 1'b1;
      kick();
      to = 1;
      for (int i = 0; i < 100; i++) begin
         if (meas_window && point_idx == 1) begin
            to = 0;
            break;
         end
         tick();
      end
      check("ab_reach", to, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_pulse", 32'(aborted), 1);
      check("ab_off", {29'd0, dds_clken, busy, meas_window}, 0);
      check("ab_pv", 32'(point_valid), 0);
      dn = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) dn++;
         tick();
      end
      check("ab_nodone", dn, 0);
      check("ab_1cy", 32'(aborted), 0);

      // start and abort together in IDLE: start wins.
      cfg(32'h0000_0001, 32'h1, 16'd1, 16'd20, 16'd1);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", 32'(busy), 1);
      check("sa_abrt", 32'(aborted), 0);

      // Asynchronous reset mid-SETTLE.
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("ar_phi", phi_inc_o, 0);
      check("ar_flags", {26'd0, dds_clken, meas_window, point_valid,
            busy, done, aborted}, 0);
      check("ar_idx", 32'(point_idx), 0);
      tick();
      cfg(32'h0000_0A00, 32'h0000_0002, 16'd2, 16'd1, 16'd1);
      reset = 1'b0;
      kick();
      check("ar_start", 32'(busy && dds_clken), 1);
      check("ar_phi0", phi_inc_o, 32'h0000_0A00);
      check("ar_idx0", 32'(point_idx), 0);
      mon(100);
      check("ar_p1", phis[1], 32'h0000_0A02);
      check("ar_pv", m_pv, 2);
      check("ar_done", m_done, 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
